// File: rtl/huffman_dec_pkg.sv
// Shared state encoding, symbol codes and widths for the Huffman decode controller.
package huffman_dec_pkg;

   typedef enum logic [1:0] {
      S_DC  = 2'd0,
      S_AC  = 2'd1,
      S_OUT = 2'd2
   } state_t;

   localparam logic [7:0] RS_EOB = 8'h00;
   localparam logic [7:0] RS_ZRL = 8'hF0;

   localparam int COEF_W    = 8;
   localparam int NUM_COEF  = 64;
   localparam int DC_PRED_W = 12;

   localparam logic [3:0] DC_SIZE_MAX = 4'd11;
   localparam logic [3:0] AC_SIZE_MAX = 4'd10;

endpackage

// File: rtl/huffman_amp_decode.sv
// Combinational JPEG amplitude decode: size + LSB-aligned amp bits -> 12-bit two's-complement value.
// A clear top amplitude bit marks a negative value stored as amp - (2^size - 1).
module huffman_amp_decode
   import huffman_dec_pkg::*;
(
   input  logic [3:0]           size,
   input  logic [15:0]          amp,
   output logic [DC_PRED_W-1:0] dec_val
);

   logic [DC_PRED_W-1:0] mask;
   logic [DC_PRED_W-1:0] mag;
   logic                 unused_amp_hi;

   // Legal sizes never exceed 11, so the top amplitude bits carry nothing.
   assign unused_amp_hi = ^amp[15:DC_PRED_W];

   always_comb begin
      mask = (DC_PRED_W'(1) << size) - DC_PRED_W'(1);
      mag  = amp[DC_PRED_W-1:0] & mask;
      if (size == 4'd0)
         dec_val = '0;
      else if (amp[size - 4'd1])
         dec_val = mag;
      else
         dec_val = mag - mask;
   end

endmodule

// File: rtl/huffman_dec_controller.sv
// Rebuilds one zigzag 8x8 block of 8-bit coefficients from parsed DC/AC Huffman symbols; one symbol per cycle,
// block_valid the cycle after the completing symbol, sym_ready low while a block is held. HUFFDEC_SAT_EN: saturate, else wrap.
module huffman_dec_controller
   import huffman_dec_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        sym_valid,
   output logic                        sym_ready,
   input  logic                        sym_is_dc,
   input  logic [7:0]                  sym_rs,
   input  logic [15:0]                 sym_amp,
   input  logic                        pred_clear,
   output logic                        block_valid,
   input  logic                        block_ready,
   output logic [NUM_COEF*COEF_W-1:0]  block_out,
   output logic                        block_err
);

   state_t                          state;
   state_t                          state_nxt;
   logic [6:0]                      pos;
   logic [6:0]                      pos_nxt;
   logic [6:0]                      pos_run;
   logic [3:0]                      run;
   logic [3:0]                      size;
   logic [DC_PRED_W-1:0]            dc_pred;
   logic [DC_PRED_W-1:0]            dc_base;
   logic [DC_PRED_W-1:0]            dc_new;
   logic [DC_PRED_W-1:0]            amp_val;
   logic [DC_PRED_W-1:0]            coef_val;
   logic [COEF_W-1:0]               coef_byte;
   logic [NUM_COEF-1:0][COEF_W-1:0] blk;
   logic                            blk_err;
   logic                            ready_en;
   logic                            sym_fire;
   logic                            blk_fire;
   logic                            err_set;
   logic                            wr_en;
   logic                            pred_upd;
   logic [5:0]                      wr_idx;

   assign run      = sym_rs[7:4];
   assign size     = sym_rs[3:0];
   assign sym_fire = sym_valid & sym_ready;
   assign blk_fire = block_valid & block_ready;
   assign pos_run  = pos + {3'd0, run};

   huffman_amp_decode u_amp_decode (
      .size    (size),
      .amp     (sym_amp),
      .dec_val (amp_val)
   );

   // A restart marker in the same cycle as a DC symbol zeroes the predictor before the add.
   assign dc_base  = pred_clear ? '0 : dc_pred;
   assign dc_new   = dc_base + amp_val;
   assign coef_val = (state == S_DC) ? dc_new : amp_val;

`ifdef HUFFDEC_SAT_EN
   always_comb begin
      if (!coef_val[11] && (coef_val[10:7] != 4'h0))
         coef_byte = 8'h7F;
      else if (coef_val[11] && (coef_val[10:7] != 4'hF))
         coef_byte = 8'h80;
      else
         coef_byte = coef_val[7:0];
   end
`else
   logic unused_coef_hi;
   assign unused_coef_hi = ^coef_val[11:8];
   assign coef_byte      = coef_val[7:0];
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= S_DC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      wr_en     = 1'b0;
      wr_idx    = '0;
      err_set   = 1'b0;
      pred_upd  = 1'b0;
      case (state)
         S_DC: begin
            if (sym_fire) begin
               if (!sym_is_dc || (size > DC_SIZE_MAX)) begin
                  err_set   = 1'b1;
                  state_nxt = S_OUT;
               end else begin
                  pred_upd  = 1'b1;
                  wr_en     = 1'b1;
                  pos_nxt   = 7'd1;
                  state_nxt = S_AC;
               end
            end
         end
         S_AC: begin
            if (sym_fire) begin
               if (sym_is_dc || (size > AC_SIZE_MAX) ||
                   ((size == 4'd0) && (run != 4'd0) && (run != 4'hF))) begin
                  err_set   = 1'b1;
                  state_nxt = S_OUT;
               end else if (sym_rs == RS_EOB) begin
                  state_nxt = S_OUT;
               end else if (sym_rs == RS_ZRL) begin
                  if (pos > 7'd48) begin
                     err_set   = 1'b1;
                     state_nxt = S_OUT;
                  end else begin
                     pos_nxt = pos + 7'd16;
                     if (pos == 7'd48)
                        state_nxt = S_OUT;
                  end
               end else if (pos_run > 7'd63) begin
                  err_set   = 1'b1;
                  state_nxt = S_OUT;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = pos_run[5:0];
                  pos_nxt = pos_run + 7'd1;
                  if (pos_run == 7'd63)
                     state_nxt = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (blk_fire) begin
               pos_nxt   = 7'd0;
               state_nxt = S_DC;
            end
         end
         default: state_nxt = S_DC;
      endcase
   end

   always_comb begin
      sym_ready   = ready_en && (state != S_OUT);
      block_valid = (state == S_OUT);
   end

   assign block_out = blk;
   assign block_err = blk_err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pos      <= '0;
         dc_pred  <= '0;
         blk      <= '0;
         blk_err  <= 1'b0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         pos      <= pos_nxt;
         if (pred_upd)
            dc_pred <= dc_new;
         else if (pred_clear)
            dc_pred <= '0;
         // The block register starts each block cleared, so skipped runs need no zero writes.
         if (blk_fire) begin
            blk     <= '0;
            blk_err <= 1'b0;
         end else begin
            if (wr_en)
               blk[wr_idx] <= coef_byte;
            if (err_set)
               blk_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_huffman_dec_controller.sv
// Bench for huffman_dec_controller: directed vectors plus random blocks against an integer reference model.
module tb_huffman_dec_controller;

   logic         clock       = 1'b0;
   logic         reset_n     = 1'b0;
   logic         sym_valid   = 1'b0;
   logic         sym_is_dc   = 1'b0;
   logic [7:0]   sym_rs      = 8'h00;
   logic [15:0]  sym_amp     = 16'h0000;
   logic         pred_clear  = 1'b0;
   logic         block_ready = 1'b0;
   logic         sym_ready;
   logic         block_valid;
   logic         block_err;
   logic [511:0] block_out;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   huffman_dec_controller dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .sym_valid   (sym_valid),
      .sym_ready   (sym_ready),
      .sym_is_dc   (sym_is_dc),
      .sym_rs      (sym_rs),
      .sym_amp     (sym_amp),
      .pred_clear  (pred_clear),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .block_out   (block_out),
      .block_err   (block_err)
   );

   // Reference model: 0 = waiting for DC, 1 = collecting AC, 2 = block finished.
   int m_phase;
   int m_pos;
   int m_pred;
   int m_byte[64];
   bit m_err;

   function automatic int amp_value(input int s, input int amp);
      int a;
      if (s == 0) return 0;
      a = amp % (1 << s);
      if (((a >> (s - 1)) & 1) == 1) return a;
      return a - ((1 << s) - 1);
   endfunction

   function automatic int to_byte(input int v);
`ifdef HUFFDEC_SAT_EN
      if (v > 127) v = 127;
      if (v < -128) v = -128;
`endif
      return v & 255;
   endfunction

   function automatic void model_clear_block();
      for (int i = 0; i < 64; i++) m_byte[i] = 0;
      m_pos   = 0;
      m_err   = 0;
      m_phase = 0;
   endfunction

   function automatic void model_reset();
      model_clear_block();
      m_pred = 0;
   endfunction

   function automatic void model_sym(input bit is_dc, input int rs, input int amp, input bit clr);
      int s;
      int run;
      int p;
      s   = rs % 16;
      run = rs / 16;
      if (clr) m_pred = 0;
      if (m_phase == 0) begin
         if (!is_dc || s > 11) begin
            m_err = 1; m_phase = 2;
         end else begin
            m_pred = (m_pred + amp_value(s, amp)) & 4095;
            p = (m_pred >= 2048) ? m_pred - 4096 : m_pred;
            m_byte[0] = to_byte(p);
            m_pos = 1; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (is_dc || s > 10 || (s == 0 && run != 0 && run != 15)) begin
            m_err = 1; m_phase = 2;
         end else if (rs == 0) begin
            m_phase = 2;
         end else if (rs == 240) begin
            if (m_pos + 16 > 64) begin
               m_err = 1; m_phase = 2;
            end else begin
               m_pos += 16;
               if (m_pos == 64) m_phase = 2;
            end
         end else if (m_pos + run > 63) begin
            m_err = 1; m_phase = 2;
         end else begin
            m_byte[m_pos + run] = to_byte(amp_value(s, amp));
            m_pos += run + 1;
            if (m_pos == 64) m_phase = 2;
         end
      end
   endfunction

   function automatic logic [511:0] expected_block();
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 64; i++) v[i*8 +: 8] = 8'(m_byte[i]);
      return v;
   endfunction

   task automatic send_sym(input bit is_dc, input logic [7:0] rs, input logic [15:0] amp, input bit clr);
      int n;
      n = 0;
      sym_valid  = 1'b1;
      sym_is_dc  = is_dc;
      sym_rs     = rs;
      sym_amp    = amp;
      pred_clear = clr;
      while (sym_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL sym_accept_timeout rs=%h sym_ready=%b required 1", rs, sym_ready);
         sym_valid  = 1'b0;
         pred_clear = 1'b0;
         return;
      end
      @(posedge clock);
      model_sym(is_dc, int'(rs), int'(amp), clr);
      @(negedge clock);
      sym_valid  = 1'b0;
      sym_is_dc  = 1'b0;
      pred_clear = 1'b0;
      checks++;
      if (block_valid !== (m_phase == 2)) begin
         errors++;
         $display("FAIL block_valid_timing rs=%h got %b required %b", rs, block_valid, (m_phase == 2));
      end
   endtask

   task automatic get_block(input int hold);
      logic [511:0] exp;
      exp = expected_block();
      checks++;
      if (block_valid !== 1'b1 || sym_ready !== 1'b0) begin
         errors++;
         $display("FAIL block_present valid=%b ready=%b required 1/0", block_valid, sym_ready);
      end
      checks++;
      if (block_out !== exp) begin
         errors++;
         $display("FAIL block_out got %h required %h", block_out, exp);
      end
      checks++;
      if (block_err !== m_err) begin
         errors++;
         $display("FAIL block_err got %b required %b", block_err, m_err);
      end
      repeat (hold) begin
         @(negedge clock);
         checks++;
         if (block_out !== exp || block_err !== m_err || block_valid !== 1'b1 || sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable valid=%b ready=%b err=%b required 1/0/%b, out %h",
                     block_valid, sym_ready, block_err, m_err, block_out);
         end
      end
      block_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      block_ready = 1'b0;
      model_clear_block();
      checks++;
      if (sym_ready !== 1'b1 || block_valid !== 1'b0 || block_out !== '0 || block_err !== 1'b0) begin
         errors++;
         $display("FAIL after_accept ready=%b valid=%b err=%b out_nonzero=%b required 1/0/0/0",
                  sym_ready, block_valid, block_err, |block_out);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (sym_ready !== 1'b0 || block_valid !== 1'b0 || block_err !== 1'b0 || block_out !== '0) begin
         errors++;
         $display("FAIL reset_state ready=%b valid=%b err=%b out_nonzero=%b required all 0",
                  sym_ready, block_valid, block_err, |block_out);
      end
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b required 1", sym_ready);
      end
   endtask

   task automatic test_basic();
      send_sym(1'b1, 8'h03, 16'h0005, 1'b0);
      send_sym(1'b0, 8'h12, 16'h0001, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== 8'h05 || block_out[23:16] !== 8'hFE) begin
         errors++;
         $display("FAIL basic_bytes byte0=%h byte2=%h required 05/fe", block_out[7:0], block_out[23:16]);
      end
      get_block(0);
      send_sym(1'b1, 8'h02, 16'h0000, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== 8'h02) begin
         errors++;
         $display("FAIL dc_prediction byte0=%h required 02", block_out[7:0]);
      end
      get_block(0);
   endtask

   task automatic test_zrl();
      send_sym(1'b1, 8'h00, 16'h0000, 1'b1);
      repeat (3) send_sym(1'b0, 8'hF0, 16'h0000, 1'b0);
      send_sym(1'b0, 8'h01, 16'h0001, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[399:392] !== 8'h01 || block_out[7:0] !== 8'h00) begin
         errors++;
         $display("FAIL zrl_byte49 byte49=%h byte0=%h required 01/00", block_out[399:392], block_out[7:0]);
      end
      get_block(0);
   endtask

   task automatic test_error();
      send_sym(1'b1, 8'h01, 16'h0001, 1'b0);
      repeat (3) send_sym(1'b0, 8'hF0, 16'h0000, 1'b0);
      send_sym(1'b0, 8'hF1, 16'h0001, 1'b0);
      checks++;
      if (block_err !== 1'b1) begin
         errors++;
         $display("FAIL run_overflow_err got %b required 1", block_err);
      end
      get_block(1);
      send_sym(1'b0, 8'h11, 16'h0001, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h0C, 16'h0FFF, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h02, 16'h0003, 1'b0);
      send_sym(1'b1, 8'h01, 16'h0001, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h02, 16'h0002, 1'b0);
      send_sym(1'b0, 8'h0B, 16'h0001, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h02, 16'h0002, 1'b0);
      send_sym(1'b0, 8'h30, 16'h0000, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h03, 16'h0004, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      get_block(0);
   endtask

   task automatic test_saturation();
      logic [7:0] exp0;
`ifdef HUFFDEC_SAT_EN
      exp0 = 8'h7F;
`else
      exp0 = 8'hC8;
`endif
      send_sym(1'b1, 8'h08, 16'h00C8, 1'b1);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== exp0) begin
         errors++;
         $display("FAIL narrowing byte0=%h required %h", block_out[7:0], exp0);
      end
      get_block(0);
   endtask

   task automatic test_full_block();
      logic [503:0] ones;
      for (int i = 0; i < 63; i++) ones[i*8 +: 8] = 8'h01;
      send_sym(1'b1, 8'h00, 16'h0000, 1'b1);
      for (int i = 0; i < 63; i++) send_sym(1'b0, 8'h01, 16'h0001, 1'b0);
      checks++;
      if (block_out[511:8] !== ones || block_valid !== 1'b1 || block_err !== 1'b0) begin
         errors++;
         $display("FAIL full_block valid=%b err=%b out %h required 1/0 and all AC bytes 01",
                  block_valid, block_err, block_out);
      end
      get_block(0);
   endtask

   task automatic test_back_pressure();
      send_sym(1'b1, 8'h04, 16'h0009, 1'b0);
      send_sym(1'b0, 8'h23, 16'h0002, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      get_block(5);
   endtask

   task automatic test_pred_clear();
      send_sym(1'b1, 8'h04, 16'h000F, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      get_block(0);
      send_sym(1'b1, 8'h03, 16'h0006, 1'b1);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== 8'h06) begin
         errors++;
         $display("FAIL clear_with_dc byte0=%h required 06", block_out[7:0]);
      end
      get_block(0);
      pred_clear = 1'b1;
      @(posedge clock);
      m_pred = 0;
      @(negedge clock);
      pred_clear = 1'b0;
      send_sym(1'b1, 8'h01, 16'h0000, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== 8'hFF) begin
         errors++;
         $display("FAIL clear_idle byte0=%h required ff", block_out[7:0]);
      end
      get_block(0);
   endtask

   task automatic test_random();
      int r;
      int run;
      int s;
      int lim;
      logic [7:0] rs;
      for (int b = 0; b < 30; b++) begin
         r = $urandom_range(0, 99);
         s = (r < 6) ? $urandom_range(12, 15) : $urandom_range(0, 11);
         rs = {4'($urandom_range(0, 15)), s[3:0]};
         send_sym(r >= 3, rs, 16'($urandom), $urandom_range(0, 9) == 0);
         while (m_phase == 1) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
               rs = 8'h00;
            end else if (r < 10) begin
               rs = 8'hF0;
            end else if (r < 12) begin
               rs = 8'($urandom);
            end else begin
               lim = 63 - m_pos;
               run = $urandom_range(0, (lim < 15) ? lim : 15);
               s   = $urandom_range(1, 10);
               rs  = {run[3:0], s[3:0]};
            end
            send_sym(r == 12, rs, 16'($urandom), $urandom_range(0, 19) == 0);
         end
         get_block($urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid();
      send_sym(1'b1, 8'h05, 16'h001F, 1'b0);
      send_sym(1'b0, 8'h13, 16'h0007, 1'b0);
      send_sym(1'b0, 8'h02, 16'h0001, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (sym_ready !== 1'b0 || block_valid !== 1'b0 || block_err !== 1'b0 || block_out !== '0) begin
         errors++;
         $display("FAIL mid_reset ready=%b valid=%b err=%b out_nonzero=%b required all 0",
                  sym_ready, block_valid, block_err, |block_out);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      send_sym(1'b1, 8'h01, 16'h0001, 1'b0);
      send_sym(1'b0, 8'h00, 16'h0000, 1'b0);
      checks++;
      if (block_out[7:0] !== 8'h01) begin
         errors++;
         $display("FAIL pred_after_reset byte0=%h required 01", block_out[7:0]);
      end
      get_block(0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_zrl();
      test_error();
      test_saturation();
      test_full_block();
      test_back_pressure();
      test_pred_clear();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
